// File: rtl/clock_divider_prog.sv
// Multi-channel programmable clock divider.
// Each channel divides clk_in by a run-time divisor D (period D cycles, high for
// floor(D/2) cycles) and emits a one-cycle tick at the start of every period.
// A new divisor is staged as "pending" and only takes over at a period boundary
// (or immediately while the channel is disabled), so a divisor change never
// produces a runt pulse. sync_restart re-phases all enabled channels at once.
module clock_divider_prog #(
    parameter  int NUM_CH      = 2,
    parameter  int DIV_W       = 8,
    parameter  int DEFAULT_DIV = 2,
    localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_in,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] en,
    input  logic              sync_restart,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]  cfg_div,
    output logic              cfg_err,
    output logic [NUM_CH-1:0] pend,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick
);

    logic cfg_acc;
    logic cfg_ch_ok;
    logic cfg_legal;

    // Ready reflects the addressed channel's pend flag; out-of-range channels
    // always accept so the request can be rejected with cfg_err.
    always_comb begin
        cfg_ready = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cfg_ch == CH_W'(i)) begin
                cfg_ready = !pend[i];
            end
        end
    end

    assign cfg_acc   = cfg_valid && cfg_ready;
    assign cfg_ch_ok = (int'(cfg_ch) < NUM_CH);
    assign cfg_legal = cfg_ch_ok && (cfg_div > DIV_W'(1));

    // Rejected requests report back one cycle after the accepting edge.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= cfg_acc && !cfg_legal;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [DIV_W-1:0] div_q;
        logic [DIV_W-1:0] div_p;
        logic [DIV_W-1:0] cnt_q;
        logic [DIV_W-1:0] cnt_inc;
        logic [DIV_W-1:0] half;
        logic             pend_q;
        logic             clk_q;
        logic             tick_q;
        logic             wr_sel;
        logic             at_wrap;

        assign half    = div_q >> 1;
        assign cnt_inc = cnt_q + DIV_W'(1);
        assign at_wrap = (cnt_q == div_q - DIV_W'(1));
        assign wr_sel  = cfg_acc && cfg_legal && (cfg_ch == CH_W'(i));

        // Channel counter, divisor swap at period boundaries, registered outputs.
        // A write accepted on this edge only sets pend; the swap below uses the
        // pend value from before the edge, so it lands on the following boundary.
        always_ff @(posedge clk_in or negedge rst_n) begin
            if (!rst_n) begin
                div_q  <= DIV_W'(DEFAULT_DIV);
                div_p  <= DIV_W'(DEFAULT_DIV);
                cnt_q  <= DIV_W'(DEFAULT_DIV - 1);
                pend_q <= 1'b0;
                clk_q  <= 1'b0;
                tick_q <= 1'b0;
            end else begin
                if (!en[i]) begin
                    clk_q  <= 1'b0;
                    tick_q <= 1'b0;
                    if (pend_q) begin
                        div_q  <= div_p;
                        pend_q <= 1'b0;
                        cnt_q  <= div_p - DIV_W'(1);
                    end else begin
                        cnt_q  <= div_q - DIV_W'(1);
                    end
                end else if (at_wrap || sync_restart) begin
                    if (pend_q) begin
                        div_q  <= div_p;
                        pend_q <= 1'b0;
                    end
                    cnt_q  <= '0;
                    clk_q  <= 1'b1;
                    tick_q <= 1'b1;
                end else begin
                    cnt_q  <= cnt_inc;
                    clk_q  <= (cnt_inc < half);
                    tick_q <= 1'b0;
                end

                if (wr_sel) begin
                    div_p  <= cfg_div;
                    pend_q <= 1'b1;
                end
            end
        end

        assign pend[i]    = pend_q;
        assign clk_out[i] = clk_q;
        assign tick[i]    = tick_q;
    end

endmodule

// File: tb/tb_clock_divider_prog.sv
// Directed bench for clock_divider_prog with three channels, so that an
// out-of-range channel number (3) is representable on cfg_ch.
module tb_clock_divider_prog;

    localparam int NUM_CH = 3;
    localparam int DIV_W  = 8;
    localparam int CH_W   = 2;

    logic              clk_in;
    logic              rst_n;
    logic [NUM_CH-1:0] en;
    logic              sync_restart;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [CH_W-1:0]   cfg_ch;
    logic [DIV_W-1:0]  cfg_div;
    logic              cfg_err;
    logic [NUM_CH-1:0] pend;
    logic [NUM_CH-1:0] clk_out;
    logic [NUM_CH-1:0] tick;

    int n_cmp = 0;
    int n_bad = 0;

    clock_divider_prog #(
        .NUM_CH     (NUM_CH),
        .DIV_W      (DIV_W),
        .DEFAULT_DIV(2)
    ) dut (
        .clk_in      (clk_in),
        .rst_n       (rst_n),
        .en          (en),
        .sync_restart(sync_restart),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_ch      (cfg_ch),
        .cfg_div     (cfg_div),
        .cfg_err     (cfg_err),
        .pend        (pend),
        .clk_out     (clk_out),
        .tick        (tick)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected summary");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One rising edge; returns on the following falling edge.
    task automatic step();
        @(posedge clk_in);
        @(negedge clk_in);
    endtask

    // Run n edges and compare channel waveforms against MSB-first patterns.
    task automatic wave(input string tag, input int n,
                        input int ch_a, input logic [31:0] clk_a, input logic [31:0] tick_a,
                        input int ch_b, input logic [31:0] clk_b, input logic [31:0] tick_b);
        for (int j = 0; j < n; j++) begin
            step();
            check($sformatf("%s clk%0d[%0d]", tag, ch_a, j), 32'(clk_out[ch_a]), 32'(clk_a[n-1-j]));
            check($sformatf("%s tick%0d[%0d]", tag, ch_a, j), 32'(tick[ch_a]), 32'(tick_a[n-1-j]));
            if (ch_b >= 0) begin
                check($sformatf("%s clk%0d[%0d]", tag, ch_b, j), 32'(clk_out[ch_b]), 32'(clk_b[n-1-j]));
                check($sformatf("%s tick%0d[%0d]", tag, ch_b, j), 32'(tick[ch_b]), 32'(tick_b[n-1-j]));
            end
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        en           = '0;
        sync_restart = 1'b0;
        cfg_valid    = 1'b0;
        cfg_ch       = '0;
        cfg_div      = '0;

        // Reset state
        #2;
        check("rst clk_out", 32'(clk_out), 32'h0);
        check("rst tick", 32'(tick), 32'h0);
        check("rst pend", 32'(pend), 32'h0);
        check("rst cfg_err", 32'(cfg_err), 32'h0);
        check("rst cfg_ready", 32'(cfg_ready), 32'h1);
        step();
        step();
        rst_n = 1'b1;
        en    = 3'b011;

        // Default divisor 2 from the first edge
        wave("def", 6, 0, 32'b101010, 32'b101010, 1, 32'b101010, 32'b101010);
        check("def pend", 32'(pend), 32'h0);

        // Ch0 -> D=5, accepted on a wrap edge so it applies one period later
        cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd5;
        check("d5 ready", 32'(cfg_ready), 32'h1);
        step();
        cfg_valid = 1'b0;
        check("d5 pend set", 32'(pend[0]), 32'h1);
        check("d5 old wrap clk", 32'(clk_out[0]), 32'h1);
        check("d5 old wrap tick", 32'(tick[0]), 32'h1);
        check("d5 no err", 32'(cfg_err), 32'h0);
        step();
        check("d5 pend hold", 32'(pend[0]), 32'h1);
        check("d5 old low", 32'(clk_out[0]), 32'h0);
        wave("d5", 10, 0, 32'b1100011000, 32'b1000010000, -1, 32'h0, 32'h0);
        check("d5 pend clr", 32'(pend[0]), 32'h0);

        // Ch1: D=4 pending, second write D=7 stalls until the first is applied
        cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_div = 8'd4;
        check("stall ready0", 32'(cfg_ready), 32'h1);
        step();
        cfg_div = 8'd7;
        check("stall pend", 32'(pend[1]), 32'h1);
        check("stall ready1", 32'(cfg_ready), 32'h0);
        step();
        check("stall ready2", 32'(cfg_ready), 32'h0);
        check("stall low", 32'(clk_out[1]), 32'h0);
        step();
        check("stall applied pend", 32'(pend[1]), 32'h0);
        check("stall ready3", 32'(cfg_ready), 32'h1);
        check("stall wrap clk", 32'(clk_out[1]), 32'h1);
        check("stall wrap tick", 32'(tick[1]), 32'h1);
        step();
        cfg_valid = 1'b0;
        check("d7 pend", 32'(pend[1]), 32'h1);
        check("d4 clk", 32'(clk_out[1]), 32'h1);
        check("d4 tick", 32'(tick[1]), 32'h0);
        wave("d7", 10, 1, 32'b0011100001, 32'b0010000001, -1, 32'h0, 32'h0);
        check("d7 pend clr", 32'(pend[1]), 32'h0);

        // Rejected requests: divisor 1, then out-of-range channel
        cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd1;
        check("err1 ready", 32'(cfg_ready), 32'h1);
        step();
        cfg_valid = 1'b0;
        check("err1 pulse", 32'(cfg_err), 32'h1);
        check("err1 pend", 32'(pend), 32'h0);
        step();
        check("err1 clear", 32'(cfg_err), 32'h0);
        cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_div = 8'd9;
        check("err2 ready", 32'(cfg_ready), 32'h1);
        step();
        cfg_valid = 1'b0;
        check("err2 pulse", 32'(cfg_err), 32'h1);
        check("err2 pend", 32'(pend), 32'h0);
        step();
        check("err2 clear", 32'(cfg_err), 32'h0);

        // Ch0 D=3, ch1 D=4, then a mid-period sync_restart
        cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd3;
        step();
        cfg_ch = 2'd1; cfg_div = 8'd4;
        step();
        cfg_valid = 1'b0;
        for (int k = 0; k < 10; k++) step();
        check("sync pre pend", 32'(pend), 32'h0);
        sync_restart = 1'b1;
        step();
        sync_restart = 1'b0;
        check("sync clk0", 32'(clk_out[0]), 32'h1);
        check("sync tick0", 32'(tick[0]), 32'h1);
        check("sync clk1", 32'(clk_out[1]), 32'h1);
        check("sync tick1", 32'(tick[1]), 32'h1);
        check("sync ch2 idle", 32'({clk_out[2], tick[2]}), 32'h0);
        wave("sync", 7, 0, 32'b0010010, 32'b0010010, 1, 32'b1001100, 32'b0001000);

        // Ch2 disabled: divisor applies on the next edge, then enable with D=4
        cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_div = 8'd4;
        step();
        cfg_valid = 1'b0;
        check("dis pend set", 32'(pend[2]), 32'h1);
        step();
        check("dis pend clr", 32'(pend[2]), 32'h0);
        en = 3'b111;
        wave("en", 5, 2, 32'b11001, 32'b10001, -1, 32'h0, 32'h0);
        en = 3'b011;
        step();
        check("en drop clk", 32'(clk_out[2]), 32'h0);
        check("en drop tick", 32'(tick[2]), 32'h0);

        // Asynchronous reset with a write pending; pending D=9 must be discarded
        cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_div = 8'd9;
        step();
        cfg_valid = 1'b0;
        check("rst2 pend before", 32'(pend[1]), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("rst2 clk_out", 32'(clk_out), 32'h0);
        check("rst2 tick", 32'(tick), 32'h0);
        check("rst2 pend", 32'(pend), 32'h0);
        step();
        step();
        rst_n = 1'b1;
        wave("post", 4, 0, 32'b1010, 32'b1010, 1, 32'b1010, 32'b1010);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
